// File: rtl/mac_row_sched.sv
// Row-stationary MAC sequencer: latches a tile config, starts the MAC and paces
// paired weight/IA row reads and IA-only streaming reads from the MAC's need requests.
module mac_row_sched #(
  parameter int unsigned IA_ROW_MEM_ADDR     = 7,
  parameter int unsigned WEIGHT_ROW_MEM_ADDR = 8
) (
  input  logic                           clk,
  input  logic                           resetn,
  input  logic                           start,
  input  logic [2:0]                     K,
  input  logic [5:0]                     IMG_W,
  input  logic [7:0]                     OC,
  input  logic [2:0]                     STRIDE,
  output logic                           busy,
  output logic                           done,
  output logic                           cfg_err,
  output logic                           mac_start,
  input  logic                           mac_done,
  input  logic                           ia_need,
  input  logic                           weight_need,
  output logic                           ia_row_mem_en,
  output logic [IA_ROW_MEM_ADDR-1:0]     ia_row_mem_addr,
  output logic                           weight_row_mem_en,
  output logic [WEIGHT_ROW_MEM_ADDR-1:0] weight_row_mem_addr,
  output logic [7:0]                     cur_oc
);

  typedef enum logic [2:0] {
    StIdle, StWLoad, StIaStream, StOcNext, StWaitMac, StFin
  } state_e;

  state_e state_q, state_d;

  logic [2:0] k_cfg_q, k_cfg_d;
  logic [5:0] img_w_q, img_w_d;
  logic [7:0] oc_cfg_q, oc_cfg_d;
  logic [2:0] stride_q, stride_d;
  logic [7:0] oc_q, oc_d;
  logic [2:0] k_q, k_d;
  logic [6:0] ia_ptr_q, ia_ptr_d;
  logic [6:0] col_end_q, col_end_d;
  logic [1:0] guard_q, guard_d;

  logic                           busy_q, busy_d;
  logic                           done_q, done_d;
  logic                           cfg_err_q, cfg_err_d;
  logic                           mac_start_q, mac_start_d;
  logic                           ia_en_q, ia_en_d;
  logic                           w_en_q, w_en_d;
  logic [IA_ROW_MEM_ADDR-1:0]     ia_addr_q, ia_addr_d;
  logic [WEIGHT_ROW_MEM_ADDR-1:0] w_addr_q, w_addr_d;

  logic       cfg_legal;
  logic       last_k;
  logic       last_oc;
  logic       at_col_end;
  logic       can_step;
  logic [6:0] col_next;
  logic [7:0] w_addr_calc;

  assign cfg_legal = (K != 3'd0) && (K <= 3'd3) && (IMG_W >= {3'b000, K}) &&
                     (OC != 8'd0) && (OC <= 8'd64) && (STRIDE != 3'd0);

  assign last_k      = (k_q == k_cfg_q - 3'd1);
  assign last_oc     = (oc_q == oc_cfg_q - 8'd1);
  assign at_col_end  = (ia_ptr_q == col_end_q);
  // col_end + STRIDE <= IMG_W - 1, written without the subtraction
  assign col_next    = col_end_q + {4'b0000, stride_q};
  assign can_step    = (col_next < {1'b0, img_w_q});
  assign w_addr_calc = oc_q * {5'b00000, k_cfg_q} + {5'b00000, k_q};

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:     if (start && cfg_legal) state_d = StWLoad;
      StWLoad:    if (weight_need && last_k) state_d = can_step ? StIaStream : StOcNext;
      StIaStream: if (ia_need && at_col_end) state_d = can_step ? StIaStream : StOcNext;
      StOcNext:   state_d = last_oc ? StWaitMac : StWLoad;
      // mac_done is stale for the first two cycles after mac_start
      StWaitMac:  if (mac_done && (guard_q == 2'd3)) state_d = StFin;
      StFin:      state_d = StIdle;
      default:    state_d = StIdle;
    endcase
  end

  always_comb begin
    k_cfg_d     = k_cfg_q;
    img_w_d     = img_w_q;
    oc_cfg_d    = oc_cfg_q;
    stride_d    = stride_q;
    oc_d        = oc_q;
    k_d         = k_q;
    ia_ptr_d    = ia_ptr_q;
    col_end_d   = col_end_q;
    guard_d     = (guard_q == 2'd3) ? guard_q : guard_q + 2'd1;
    cfg_err_d   = 1'b0;
    mac_start_d = 1'b0;
    ia_en_d     = 1'b0;
    w_en_d      = 1'b0;
    ia_addr_d   = ia_addr_q;
    w_addr_d    = w_addr_q;
    busy_d      = (state_d != StIdle) && (state_d != StFin);
    done_d      = (state_d == StFin);

    unique case (state_q)
      StIdle: begin
        if (start && cfg_legal) begin
          k_cfg_d     = K;
          img_w_d     = IMG_W;
          oc_cfg_d    = OC;
          stride_d    = STRIDE;
          oc_d        = 8'd0;
          k_d         = 3'd0;
          ia_ptr_d    = 7'd0;
          col_end_d   = {4'b0000, K} - 7'd1;
          guard_d     = 2'd0;
          mac_start_d = 1'b1;
        end else if (start) begin
          cfg_err_d = 1'b1;
        end
      end
      StWLoad: begin
        if (weight_need) begin
          ia_en_d   = 1'b1;
          w_en_d    = 1'b1;
          ia_addr_d = IA_ROW_MEM_ADDR'(ia_ptr_q);
          w_addr_d  = WEIGHT_ROW_MEM_ADDR'(w_addr_calc);
          k_d       = k_q + 3'd1;
          ia_ptr_d  = ia_ptr_q + 7'd1;
          if (last_k && can_step) col_end_d = col_next;
        end
      end
      StIaStream: begin
        if (ia_need) begin
          ia_en_d   = 1'b1;
          ia_addr_d = IA_ROW_MEM_ADDR'(ia_ptr_q);
          ia_ptr_d  = ia_ptr_q + 7'd1;
          if (at_col_end && can_step) col_end_d = col_next;
        end
      end
      StOcNext: begin
        if (!last_oc) begin
          oc_d      = oc_q + 8'd1;
          k_d       = 3'd0;
          ia_ptr_d  = 7'd0;
          col_end_d = {4'b0000, k_cfg_q} - 7'd1;
        end
      end
      StWaitMac, StFin: ;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      k_cfg_q     <= '0;
      img_w_q     <= '0;
      oc_cfg_q    <= '0;
      stride_q    <= '0;
      oc_q        <= '0;
      k_q         <= '0;
      ia_ptr_q    <= '0;
      col_end_q   <= '0;
      guard_q     <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      cfg_err_q   <= 1'b0;
      mac_start_q <= 1'b0;
      ia_en_q     <= 1'b0;
      w_en_q      <= 1'b0;
      ia_addr_q   <= '0;
      w_addr_q    <= '0;
    end else begin
      k_cfg_q     <= k_cfg_d;
      img_w_q     <= img_w_d;
      oc_cfg_q    <= oc_cfg_d;
      stride_q    <= stride_d;
      oc_q        <= oc_d;
      k_q         <= k_d;
      ia_ptr_q    <= ia_ptr_d;
      col_end_q   <= col_end_d;
      guard_q     <= guard_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      cfg_err_q   <= cfg_err_d;
      mac_start_q <= mac_start_d;
      ia_en_q     <= ia_en_d;
      w_en_q      <= w_en_d;
      ia_addr_q   <= ia_addr_d;
      w_addr_q    <= w_addr_d;
    end
  end

  assign busy                = busy_q;
  assign done                = done_q;
  assign cfg_err             = cfg_err_q;
  assign mac_start           = mac_start_q;
  assign ia_row_mem_en       = ia_en_q;
  assign ia_row_mem_addr     = ia_addr_q;
  assign weight_row_mem_en   = w_en_q;
  assign weight_row_mem_addr = w_addr_q;
  assign cur_oc              = oc_q;

endmodule

// File: tb/tb_mac_row_sched.sv
// Bench for mac_row_sched: a read-list reference model checked every cycle, a config
// table with hand-computed read counts, and hand-written reset/drain sequences.
module tb_mac_row_sched;

  logic       clk = 1'b0;
  logic       resetn = 1'b1;
  logic       start = 1'b0;
  logic [2:0] K = '0;
  logic [5:0] IMG_W = '0;
  logic [7:0] OC = '0;
  logic [2:0] STRIDE = '0;
  logic       busy, done, cfg_err, mac_start;
  logic       mac_done = 1'b0;
  logic       ia_need = 1'b0;
  logic       weight_need = 1'b0;
  logic       ia_row_mem_en, weight_row_mem_en;
  logic [6:0] ia_row_mem_addr;
  logic [7:0] weight_row_mem_addr;
  logic [7:0] cur_oc;

  mac_row_sched #(.IA_ROW_MEM_ADDR(7), .WEIGHT_ROW_MEM_ADDR(8)) dut (
    .clk                 (clk),
    .resetn              (resetn),
    .start               (start),
    .K                   (K),
    .IMG_W               (IMG_W),
    .OC                  (OC),
    .STRIDE              (STRIDE),
    .busy                (busy),
    .done                (done),
    .cfg_err             (cfg_err),
    .mac_start           (mac_start),
    .mac_done            (mac_done),
    .ia_need             (ia_need),
    .weight_need         (weight_need),
    .ia_row_mem_en       (ia_row_mem_en),
    .ia_row_mem_addr     (ia_row_mem_addr),
    .weight_row_mem_en   (weight_row_mem_en),
    .weight_row_mem_addr (weight_row_mem_addr),
    .cur_oc              (cur_oc)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endfunction

  // Reference model: the tile is the ordered list of reads the MAC will consume.
  typedef struct {bit w; int ia; int wa; int ch; bit last;} rd_t;
  rd_t rd[$];
  int  idx, phase, since, m_cur_oc, e_ia, e_wa;  // phase: 0 idle 1 read 2 bubble 3 wait 4 fin
  bit  e_busy, e_done, e_err, e_mst, e_iae, e_we;
  int  n_ia, n_w;
  bit  first_err, first_mst;

  function automatic bit legal(int k, int iw, int oc, int s);
    return k >= 1 && k <= 3 && iw >= k && iw <= 63 && oc >= 1 && oc <= 64 && s >= 1 && s <= 7;
  endfunction

  function automatic void build(int k, int iw, int oc, int s);
    int ow, n;
    rd_t r;
    rd.delete();
    ow = (iw - k) / s + 1;
    n  = k + (ow - 1) * s;
    for (int ch = 0; ch < oc; ch++) begin
      for (int a = 0; a < n; a++) begin
        r.w    = (a < k);
        r.ia   = a;
        r.wa   = ch * k + a;
        r.ch   = ch;
        r.last = (a == n - 1);
        rd.push_back(r);
      end
    end
  endfunction

  function automatic void model_reset();
    rd.delete();
    idx = 0; phase = 0; since = 0; m_cur_oc = 0; e_ia = 0; e_wa = 0;
    {e_busy, e_done, e_err, e_mst, e_iae, e_we} = '0;
  endfunction

  function automatic void model_step(bit st, int k, int iw, int oc, int s,
                                     bit ian, bit wn, bit md);
    rd_t r;
    {e_done, e_err, e_mst, e_iae, e_we} = '0;
    case (phase)
      0: if (st) begin
        if (legal(k, iw, oc, s)) begin
          build(k, iw, oc, s);
          idx = 0; phase = 1; e_mst = 1; m_cur_oc = 0; since = -1;
        end else e_err = 1;
      end
      1: begin
        r = rd[idx];
        if (r.w ? wn : ian) begin
          e_iae = 1; e_ia = r.ia;
          if (r.w) begin e_we = 1; e_wa = r.wa; end
          idx++;
          if (r.last) phase = 2;
        end
      end
      2: if (idx == rd.size()) phase = 3;
         else begin m_cur_oc = rd[idx].ch; phase = 1; end
      3: if (md && since >= 3) begin phase = 4; e_done = 1; end
      default: phase = 0;
    endcase
    e_busy = (phase >= 1 && phase <= 3);
    since++;
  endfunction

  function automatic logic [31:0] dut_vec();
    return 32'({busy, done, cfg_err, mac_start, ia_row_mem_en, weight_row_mem_en,
                ia_row_mem_addr, weight_row_mem_addr, cur_oc});
  endfunction

  function automatic logic [31:0] exp_vec();
    return 32'({e_busy, e_done, e_err, e_mst, e_iae, e_we, 7'(e_ia), 8'(e_wa), 8'(m_cur_oc)});
  endfunction

  task automatic step(input bit st, input int k, input int iw, input int oc, input int s,
                      input bit ian, input bit wn, input bit md);
    start = st; K = 3'(k); IMG_W = 6'(iw); OC = 8'(oc); STRIDE = 3'(s);
    ia_need = ian; weight_need = wn; mac_done = md;
    model_step(st, int'(K), int'(IMG_W), int'(OC), int'(STRIDE), ian, wn, md);
    @(posedge clk); #1;
    check("cycle", dut_vec(), exp_vec());
    if (ia_row_mem_en) n_ia++;
    if (weight_row_mem_en) n_w++;
  endtask

  task automatic idle_step();
    step(0, 0, 0, 0, 0, 1, 1, 0);
  endtask

  // Launch a tile and run it to completion; config inputs are scrambled after launch.
  task automatic run_tile(input int k, input int iw, input int oc, input int s, input bit thr);
    bit ian, wn, md;
    n_ia = 0; n_w = 0;
    step(1, k, iw, oc, s, 0, 0, 0);
    first_err = cfg_err; first_mst = mac_start;
    for (int c = 0; c < 20000 && phase != 0; c++) begin
      ian = thr ? 1'($urandom_range(0, 1)) : 1'b1;
      wn  = thr ? 1'($urandom_range(0, 1)) : 1'b1;
      md  = thr ? 1'($urandom_range(0, 1)) : 1'b1;
      step(1'($urandom_range(0, 1)), int'($urandom_range(0, 7)), int'($urandom_range(0, 63)),
           int'($urandom_range(0, 255)), int'($urandom_range(0, 7)), ian, wn, md);
    end
    for (int c = 0; c < 3; c++) idle_step();
    check("tile_end_busy", 32'(busy), 32'd0);
  endtask

  typedef struct {int k; int iw; int oc; int s; bit thr; bit err; int n_ia; int n_w;} vec_t;

  initial begin
    vec_t tbl[12];
    int   k, iw, oc, s;

    tbl[0]  = '{3, 8,  2,  1, 0, 0, 16, 6};
    tbl[1]  = '{3, 8,  1,  2, 0, 0, 7,  3};
    tbl[2]  = '{3, 8,  2,  1, 1, 0, 16, 6};
    tbl[3]  = '{0, 8,  1,  1, 0, 1, 0,  0};
    tbl[4]  = '{3, 8,  1,  0, 0, 1, 0,  0};
    tbl[5]  = '{3, 2,  1,  1, 0, 1, 0,  0};
    tbl[6]  = '{3, 63, 1,  7, 1, 0, 59, 3};
    tbl[7]  = '{2, 10, 3,  3, 1, 0, 24, 6};
    tbl[8]  = '{1, 5,  1,  5, 0, 0, 1,  1};
    tbl[9]  = '{2, 8,  65, 1, 0, 1, 0,  0};
    tbl[10] = '{1, 1,  1,  1, 1, 0, 1,  1};
    tbl[11] = '{2, 9,  4,  2, 1, 0, 32, 8};

    model_reset();
    #2 resetn = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    check("reset_state", dut_vec(), 32'd0);
    resetn = 1'b1;

    foreach (tbl[i]) begin
      run_tile(tbl[i].k, tbl[i].iw, tbl[i].oc, tbl[i].s, tbl[i].thr);
      check($sformatf("tbl%0d_cfg_err", i), 32'(first_err), 32'(tbl[i].err));
      check($sformatf("tbl%0d_mac_start", i), 32'(first_mst), 32'(!tbl[i].err));
      check($sformatf("tbl%0d_n_ia", i), 32'(n_ia), 32'(tbl[i].n_ia));
      check($sformatf("tbl%0d_n_w", i), 32'(n_w), 32'(tbl[i].n_w));
    end

    for (int t = 0; t < 6; t++) begin
      k  = int'($urandom_range(1, 3));
      iw = int'($urandom_range(k, 63));
      oc = int'($urandom_range(1, 6));
      s  = int'($urandom_range(1, 7));
      run_tile(k, iw, oc, s, 1'b1);
    end

    // Reset while streaming IA for channel 1, then restart from scratch.
    step(1, 3, 8, 2, 1, 0, 0, 0);
    for (int c = 0; c < 200 && !(phase == 1 && rd[idx].ch == 1 && !rd[idx].w); c++) idle_step();
    idle_step();
    idle_step();
    check("mid_reset_oc1", 32'(cur_oc), 32'd1);
    resetn = 1'b0;
    #1;
    check("mid_reset_async", dut_vec(), 32'd0);
    model_reset();
    @(posedge clk); #1;
    check("mid_reset_held", dut_vec(), 32'd0);
    resetn = 1'b1;
    step(1, 3, 8, 2, 1, 0, 0, 0);
    idle_step();
    check("restart_first_read",
          32'({ia_row_mem_en, weight_row_mem_en, ia_row_mem_addr, weight_row_mem_addr}),
          32'({1'b1, 1'b1, 7'd0, 8'd0}));
    for (int c = 0; c < 200 && phase != 0; c++) step(0, 0, 0, 0, 0, 1, 1, 1);
    check("restart_idle", 32'(busy), 32'd0);

    // Drain: 64 single-tap channels, MAC holds done low, stray start ignored.
    n_w = 0;
    step(1, 1, 1, 64, 1, 0, 0, 0);
    for (int c = 0; c < 1000 && phase != 3; c++) step(0, 0, 0, 0, 0, 1, 1, 0);
    check("drain_n_w", 32'(n_w), 32'd64);
    for (int c = 0; c < 6; c++) step(c == 2, 3, 8, 1, 1, 1, 1, 0);
    check("drain_busy_hold", 32'(busy), 32'd1);
    check("drain_no_done", 32'(done), 32'd0);
    step(0, 0, 0, 0, 0, 0, 0, 1);
    check("drain_done", 32'({done, busy}), 32'({1'b1, 1'b0}));
    idle_step();
    check("drain_done_pulse", 32'({done, busy}), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
